reg_file_gen: RTL and testbench



---
 rtl/cpu_pkg.sv | 12 +
 rtl/reg_file_gen_if.sv | 29 ++
 rtl/rf_clear_seq.sv | 57 +++++
 rtl/reg_file_gen.sv | 83 ++++++++
 tb/tb_reg_file_gen.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath types and register-file defaults
package cpu_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int CPU_WIDTH = 8;
  localparam int CPU_DEPTH = 4;

endpackage

// File: rtl/reg_file_gen_if.sv
// rtl/reg_file_gen_if.sv - write/read/reserve/clear bus of the register file
interface reg_file_gen_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             busy_a;
  logic             busy_b;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             clr_req;
  logic             clr_busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr, clr_req,
    input  rd_data_a, rd_data_b, busy_a, busy_b, clr_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr, clr_req,
    output rd_data_a, rd_data_b, busy_a, busy_b, clr_busy
  );
endinterface

// File: rtl/rf_clear_seq.sv
// rtl/rf_clear_seq.sv - soft-clear sequencer: one entry zeroed per cycle, 0..DEPTH-1
module rf_clear_seq
  import cpu_pkg::*;
#(
  parameter  int DEPTH = CPU_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_e     state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RF_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // ptr parks on LAST when the pass ends; a new request restarts it at 0
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      RF_IDLE: begin
        if (clr_req) begin
          state_nxt = RF_CLEAR;
          ptr_nxt   = '0;
        end
      end
      RF_CLEAR: begin
        if (ptr == LAST) begin
          state_nxt = RF_IDLE;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      default: state_nxt = RF_IDLE;
    endcase
  end

  assign clr_busy = (state == RF_CLEAR);
  assign clr_we   = (state == RF_CLEAR);
  assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_gen.sv
// rtl/reg_file_gen.sv - 1W/2R register file with bypass, zero register, pending scoreboard, soft-clear
module reg_file_gen
  import cpu_pkg::*;
#(
  parameter int WIDTH   = CPU_WIDTH,
  parameter int DEPTH   = CPU_DEPTH,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0
) (
  input logic           clk,
  input logic           rst_n,
  reg_file_gen_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;

  logic             clr_busy;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             user_we;
  logic             user_rsv;

  rf_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (bus.clr_req),
    .clr_busy(clr_busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  assign bus.clr_busy = clr_busy;

  // the zero register swallows writes and reservations so it never goes pending
  assign user_we  = bus.wr_en  && !clr_busy && !((R0_ZERO != 0) && (bus.wr_addr  == '0));
  assign user_rsv = bus.rsv_en && !clr_busy && !((R0_ZERO != 0) && (bus.rsv_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      pend <= '0;
    end else if (clr_we) begin
      mem[clr_addr]  <= '0;
      pend[clr_addr] <= 1'b0;
    end else begin
      if (user_we) begin
        mem[bus.wr_addr]  <= bus.wr_data;
        pend[bus.wr_addr] <= 1'b0;
      end
      // placed after the write so a same-address reservation keeps the entry pending
      if (user_rsv) begin
        pend[bus.rsv_addr] <= 1'b1;
      end
    end
  end

  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];
  logic             busy    [2];

  assign rd_addr[0]    = bus.rd_addr_a;
  assign rd_addr[1]    = bus.rd_addr_b;
  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];
  assign bus.busy_a    = busy[0];
  assign bus.busy_b    = busy[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic fwd;
    logic zero;

    assign fwd        = (BYPASS != 0) && user_we && (bus.wr_addr == rd_addr[p]);
    assign zero       = (R0_ZERO != 0) && (rd_addr[p] == '0);
    assign rd_data[p] = zero ? '0 : (fwd ? bus.wr_data : mem[rd_addr[p]]);
    assign busy[p]    = fwd ? 1'b0 : pend[rd_addr[p]];
  end

endmodule

// File: tb/tb_reg_file_gen.sv
// tb/tb_reg_file_gen.sv - scoreboard bench over BYPASS=1, BYPASS=0 and R0_ZERO=1 instances
module tb_reg_file_gen;

  localparam int D0 = 0;
  localparam int D1 = 8;
  localparam int D2 = 16;
  localparam int RA = 0;
  localparam int RB = 1;
  localparam int BA = 2;
  localparam int BB = 3;
  localparam int CB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;
  logic       rsv_en;
  logic [1:0] rsv_addr;
  logic       clr_req;

  logic [7:0] rda [3];
  logic [7:0] rdb [3];
  logic       ba  [3];
  logic       bb  [3];
  logic       cb  [3];

  always #5 clk = ~clk;

  // instance 0: bypass on, instance 1: bypass off, instance 2: bypass on with zero register
  for (genvar i = 0; i < 3; i++) begin : g_dut
    reg_file_gen_if #(.WIDTH(8), .AW(2)) bus ();

    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign bus.rd_addr_a = rd_addr_a;
    assign bus.rd_addr_b = rd_addr_b;
    assign bus.rsv_en    = rsv_en;
    assign bus.rsv_addr  = rsv_addr;
    assign bus.clr_req   = clr_req;
    assign rda[i]        = bus.rd_data_a;
    assign rdb[i]        = bus.rd_data_b;
    assign ba[i]         = bus.busy_a;
    assign bb[i]         = bus.busy_b;
    assign cb[i]         = bus.clr_busy;

    reg_file_gen #(
      .WIDTH  (8),
      .DEPTH  (4),
      .BYPASS ((i == 1) ? 0 : 1),
      .R0_ZERO((i == 2) ? 1 : 0)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );
  end

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic logic [7:0] obs(input int sel);
    int d;
    d = sel / 8;
    case (sel % 8)
      RA:      return rda[d];
      RB:      return rdb[d];
      BA:      return {7'b0, ba[d]};
      BB:      return {7'b0, bb[d]};
      default: return {7'b0, cb[d]};
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic set_in(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                        input logic [1:0] ra, input logic [1:0] rb,
                        input logic rsv, input logic [1:0] rsva, input logic clr);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
    rsv_en    = rsv;
    rsv_addr  = rsva;
    clr_req   = clr;
  endtask

  // sample mid-cycle, drain the scoreboard, then move to just after the next edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, obs(e.sel), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(0, 0, 8'h00, 1, 2, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    push("rst_rd_a", D0 + RA, 8'h00);
    push("rst_rd_b", D0 + RB, 8'h00);
    push("rst_busy_a", D0 + BA, 8'h00);
    push("rst_busy_b", D0 + BB, 8'h00);
    push("rst_clr_busy", D0 + CB, 8'h00);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      set_in(1, 2'(i), 8'(12 + i), 0, 0, 0, 0, 0);
      step();
    end

    set_in(0, 0, 8'h00, 1, 3, 0, 0, 0);
    push("rd_1", D0 + RA, 8'd13);
    push("rd_3", D0 + RB, 8'd15);
    push("nb_rd_1", D1 + RA, 8'd13);
    push("nb_rd_3", D1 + RB, 8'd15);
    step();
    set_in(0, 0, 8'h00, 2, 0, 0, 0, 0);
    push("rd_2", D0 + RA, 8'd14);
    push("rd_0", D0 + RB, 8'd12);
    push("nb_rd_0", D1 + RB, 8'd12);
    push("r0_rd_2", D2 + RA, 8'd14);
    push("r0_rd_0", D2 + RB, 8'd0);
    step();

    set_in(1, 2, 8'hA5, 2, 0, 0, 0, 0);
    push("byp_same_cycle", D0 + RA, 8'hA5);
    push("nobyp_old", D1 + RA, 8'd14);
    push("byp_busy", D0 + BA, 8'h00);
    step();
    set_in(0, 0, 8'h00, 2, 0, 0, 0, 0);
    push("nobyp_next", D1 + RA, 8'hA5);
    step();

    set_in(0, 0, 8'h00, 3, 3, 1, 3, 0);
    push("rsv_busy_same", D0 + BA, 8'h00);
    step();
    set_in(0, 0, 8'h00, 3, 3, 0, 0, 0);
    push("rsv_busy_a", D0 + BA, 8'h01);
    push("nb_rsv_busy_b", D1 + BB, 8'h01);
    step();
    set_in(1, 3, 8'h33, 3, 3, 0, 0, 0);
    push("wr_fwd_busy", D0 + BA, 8'h00);
    push("wr_fwd_data", D0 + RA, 8'h33);
    push("nb_wr_busy", D1 + BA, 8'h01);
    push("nb_wr_data", D1 + RA, 8'd15);
    step();
    set_in(0, 0, 8'h00, 3, 3, 0, 0, 0);
    push("nb_wr_busy_next", D1 + BA, 8'h00);
    push("nb_wr_data_next", D1 + RA, 8'h33);
    step();
    set_in(1, 3, 8'h44, 3, 3, 1, 3, 0);
    push("rsvwr_fwd_data", D0 + RA, 8'h44);
    push("rsvwr_fwd_busy", D0 + BA, 8'h00);
    push("nb_rsvwr_busy", D1 + BA, 8'h00);
    step();
    set_in(0, 0, 8'h00, 3, 3, 0, 0, 0);
    push("rsvwr_busy", D0 + BA, 8'h01);
    push("nb_rsvwr_busy_b", D1 + BB, 8'h01);
    push("rsvwr_data", D0 + RA, 8'h44);
    push("nb_rsvwr_data", D1 + RB, 8'h44);
    step();

    set_in(1, 0, 8'h7F, 0, 0, 1, 0, 0);
    push("r0_wr_rd", D2 + RA, 8'h00);
    push("r0_wr_busy", D2 + BA, 8'h00);
    push("e0_fwd", D0 + RA, 8'h7F);
    step();
    set_in(0, 0, 8'h00, 0, 0, 0, 0, 0);
    push("r0_rd_after", D2 + RA, 8'h00);
    push("r0_busy_after", D2 + BB, 8'h00);
    push("e0_data_after", D0 + RB, 8'h7F);
    push("e0_busy_after", D0 + BA, 8'h01);
    step();

    for (int i = 0; i < 4; i++) begin
      set_in(1, 2'(i), 8'hFF, 0, 0, 0, 0, 0);
      step();
    end
    set_in(0, 0, 8'h00, 0, 0, 0, 0, 1);
    push("clr_req_cycle", D0 + CB, 8'h00);
    step();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 2'(k), 8'h5A, 2'(k), 2'(k + 3), 1, 2'(k), 0);
      push("clr_busy_hi", D0 + CB, 8'h01);
      push("clr_cur_entry", D0 + RA, 8'hFF);
      push("nb_clr_cur_entry", D1 + RA, 8'hFF);
      push("clr_no_busy", D0 + BA, 8'h00);
      push("clr_prev_entry", D0 + RB, (k == 0) ? 8'hFF : 8'h00);
      step();
    end
    set_in(1, 2, 8'h66, 0, 1, 0, 0, 0);
    push("clr_busy_lo", D0 + CB, 8'h00);
    push("clr_rd_0", D0 + RA, 8'h00);
    push("clr_rd_1", D0 + RB, 8'h00);
    push("nb_clr_rd_0", D1 + RA, 8'h00);
    push("clr_busy_0", D0 + BA, 8'h00);
    step();
    set_in(0, 0, 8'h00, 3, 2, 0, 0, 0);
    push("clr_rd_3", D0 + RA, 8'h00);
    push("clr_busy_3", D0 + BA, 8'h00);
    push("post_clr_wr", D1 + RB, 8'h66);
    push("post_clr_wr_b", D0 + RB, 8'h66);
    step();

    set_in(1, 1, 8'h11, 0, 0, 0, 0, 0);
    step();
    set_in(0, 0, 8'h00, 2, 1, 0, 0, 1);
    step();
    set_in(0, 0, 8'h00, 2, 1, 0, 0, 0);
    push("mid_clr_busy0", D0 + CB, 8'h01);
    step();
    push("mid_clr_busy1", D0 + CB, 8'h01);
    push("mid_clr_rd_2", D0 + RA, 8'h66);
    push("mid_clr_rd_1", D0 + RB, 8'h11);
    step();
    rst_n = 1'b0;
    push("rst_mid_clr_busy", D0 + CB, 8'h00);
    push("rst_mid_rd_2", D0 + RA, 8'h00);
    push("rst_mid_rd_1", D0 + RB, 8'h00);
    push("nb_rst_mid_rd_2", D1 + RA, 8'h00);
    push("r0_rst_mid_rd_1", D2 + RB, 8'h00);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
